// File: rtl/fetch_buffer_pkg.sv
// Shared definitions for the fetch buffer: superscalar width, default depth
// and the fetch-to-decode packet layout.
package fetch_buffer_pkg;

  localparam int unsigned N          = 4;   // superscalar width
  localparam int unsigned FB_ENTRIES = 16;  // default fetch buffer depth

  typedef struct packed {
    logic        valid;
    logic [31:0] inst;
    logic [31:0] PC;
    logic [31:0] NPC;
  } IF_ID_PACKET;

endpackage

// File: rtl/fetch_buffer_prefix_count.sv
// prefix_count: counts the contiguous run of set bits starting at bit 0 and
// flags whether any set bit appears after the first clear one.
module prefix_count #(
  parameter  int unsigned W  = 4,
  localparam int unsigned CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  valid_i,
  output logic [CW-1:0] count_o,
  output logic          contig_o
);

  // Leading-ones count plus contiguity check in a single scan.
  always_comb begin
    logic run;
    count_o  = '0;
    contig_o = 1'b1;
    run      = 1'b1;
    for (int unsigned i = 0; i < W; i++) begin
      if (valid_i[i]) begin
        if (run) count_o = count_o + CW'(1);
        else     contig_o = 1'b0;
      end else begin
        run = 1'b0;
      end
    end
  end

endmodule

// File: rtl/fetch_buffer.sv
// fetch_buffer: circular instruction queue between fetch and id_stage.
// Accepts up to WIDTH packets per cycle (all-or-nothing) and presents the
// WIDTH oldest entries in program order. Flushed by nuke.
// Optional macro FB_EARLY_FREE_EN: stall also credits slots freed by this
// cycle's dispatch (adds a dispatch_num -> fb_stall combinational path).
module fetch_buffer
  import fetch_buffer_pkg::*;
#(
  parameter int unsigned WIDTH   = N,
  parameter int unsigned FB_SIZE = FB_ENTRIES
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           nuke,
  input  IF_ID_PACKET [WIDTH-1:0]        if_packet_in,
  input  logic [$clog2(WIDTH+1)-1:0]     dispatch_num,
  output IF_ID_PACKET [WIDTH-1:0]        if_id_packet_out,
  output logic [$clog2(FB_SIZE+1)-1:0]   fb_count,
  output logic                           fb_stall
);

  localparam int unsigned IDX_W = $clog2(FB_SIZE);
  localparam int unsigned CNT_W = $clog2(FB_SIZE + 1);
  localparam int unsigned LN_W  = $clog2(WIDTH + 1);

  IF_ID_PACKET      entries_q [FB_SIZE];
  logic [IDX_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] free_slots;
  logic [WIDTH-1:0] in_valid;
  logic [LN_W-1:0]  n_in, n_out, avail;
  logic             in_contig;
  logic             accept;

  // Gather per-lane valid bits for the prefix counter.
  always_comb begin
    in_valid = '0;
    for (int unsigned j = 0; j < WIDTH; j++) in_valid[j] = if_packet_in[j].valid;
  end

  prefix_count #(.W(WIDTH)) u_prefix_count (
    .valid_i  (in_valid),
    .count_o  (n_in),
    .contig_o (in_contig)
  );

  // Dispatch clamp, stall decision and next-state pointers/count.
  always_comb begin
    avail = (count_q >= CNT_W'(WIDTH)) ? LN_W'(WIDTH) : LN_W'(count_q);
    n_out = (dispatch_num < avail) ? dispatch_num : avail;
`ifdef FB_EARLY_FREE_EN
    free_slots = CNT_W'(FB_SIZE) - count_q + CNT_W'(n_out);
`else
    free_slots = CNT_W'(FB_SIZE) - count_q;
`endif
    fb_stall = (free_slots < CNT_W'(WIDTH));
    accept   = !fb_stall;
    head_d   = head_q + IDX_W'(n_out);
    tail_d   = tail_q + (accept ? IDX_W'(n_in) : '0);
    count_d  = count_q + (accept ? CNT_W'(n_in) : '0) - CNT_W'(n_out);
    if (nuke) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  // Pointer/count registers and entry array; dequeue clears precede enqueue
  // writes so a slot freed and refilled in one cycle keeps the new packet.
  always_ff @(posedge clock) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < FB_SIZE; i++) entries_q[i] <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (nuke) begin
        for (int unsigned i = 0; i < FB_SIZE; i++) entries_q[i].valid <= 1'b0;
      end else begin
        for (int unsigned i = 0; i < WIDTH; i++)
          if (LN_W'(i) < n_out) entries_q[head_q + IDX_W'(i)].valid <= 1'b0;
        if (accept)
          for (int unsigned j = 0; j < WIDTH; j++)
            if (LN_W'(j) < n_in) entries_q[tail_q + IDX_W'(j)] <= if_packet_in[j];
      end
    end
  end

  // Present the oldest WIDTH entries; lanes beyond the occupancy read as zero.
  always_comb begin
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if_id_packet_out[i] = '0;
      if (CNT_W'(i) < count_q) if_id_packet_out[i] = entries_q[head_q + IDX_W'(i)];
    end
  end

  assign fb_count = count_q;

  a_contig_lanes: assert property (@(posedge clock) disable iff (reset) in_contig)
    else $error("if_packet_in valid lanes are not a contiguous prefix");
  a_dispatch_range: assert property (@(posedge clock) disable iff (reset) dispatch_num <= avail)
    else $error("dispatch_num exceeds valid output lanes");

endmodule

// File: tb/tb_fetch_buffer.sv
// Self-checking bench for fetch_buffer: directed scenarios followed by a
// randomized run, all compared against a queue-based reference model.
module tb_fetch_buffer;
  import fetch_buffer_pkg::*;

  localparam int unsigned W  = N;
  localparam int unsigned FS = FB_ENTRIES;

  logic                       clock = 1'b0;
  logic                       reset;
  logic                       nuke;
  IF_ID_PACKET [W-1:0]        if_packet_in;
  logic [$clog2(W+1)-1:0]     dispatch_num;
  IF_ID_PACKET [W-1:0]        if_id_packet_out;
  logic [$clog2(FS+1)-1:0]    fb_count;
  logic                       fb_stall;

  fetch_buffer #(.WIDTH(W), .FB_SIZE(FS)) dut (
    .clock            (clock),
    .reset            (reset),
    .nuke             (nuke),
    .if_packet_in     (if_packet_in),
    .dispatch_num     (dispatch_num),
    .if_id_packet_out (if_id_packet_out),
    .fb_count         (fb_count),
    .fb_stall         (fb_stall)
  );

  always #5 clock = ~clock;

  int unsigned errors = 0;
  int unsigned checks = 0;
  IF_ID_PACKET model_q[$];
  logic [31:0] pc_next = '0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int unsigned min2(input int unsigned a, input int unsigned b);
    return (a < b) ? a : b;
  endfunction

  // Compare registered-state outputs with the model at the negative edge.
  task automatic check_state(input string ph);
    IF_ID_PACKET exp;
    check_eq({ph, ".count"}, fb_count, model_q.size());
    for (int i = 0; i < W; i++) begin
      exp = (i < model_q.size()) ? model_q[i] : '0;
      check_eq($sformatf("%s.lane%0d", ph, i), if_id_packet_out[i], exp);
    end
  endtask

  // One clock: drive inputs, check stall, advance the model, check outputs.
  task automatic cycle(input string ph, input int unsigned nin, input int unsigned disp,
                       input bit nk, input bit rst);
    IF_ID_PACKET grp [W];
    int unsigned sz, nout, free_cnt;
    bit          exp_stall;
    for (int j = 0; j < W; j++) begin
      grp[j].inst = $urandom;
      if (rst) begin
        grp[j].valid = 1'($urandom);
        grp[j].PC    = $urandom;
        grp[j].NPC   = $urandom;
      end else if (j < nin) begin
        grp[j].valid = 1'b1;
        grp[j].PC    = pc_next + 32'(4 * j);
        grp[j].NPC   = pc_next + 32'(4 * j + 4);
      end else begin
        grp[j].valid = 1'b0;
        grp[j].PC    = $urandom;
        grp[j].NPC   = $urandom;
      end
      if_packet_in[j] = grp[j];
    end
    dispatch_num = rst ? 3'($urandom_range(0, W)) : 3'(disp);
    nuke  = nk;
    reset = rst;
    sz       = model_q.size();
    nout     = min2(disp, min2(sz, W));
    free_cnt = FS - sz;
`ifdef FB_EARLY_FREE_EN
    free_cnt = free_cnt + nout;
`endif
    exp_stall = (free_cnt < W);
    #1;
    if (!rst) check_eq({ph, ".stall"}, fb_stall, exp_stall);
    @(posedge clock);
    if (rst || nk) begin
      model_q.delete();
    end else begin
      repeat (nout) void'(model_q.pop_front());
      if (!exp_stall) begin
        for (int j = 0; j < nin; j++) model_q.push_back(grp[j]);
        pc_next = pc_next + 32'(4 * nin);
      end
    end
    @(negedge clock);
    check_state(ph);
  endtask

  initial begin
    int unsigned nin, disp;
    bit nk, rst;

    // Reset with garbage inputs.
    cycle("rst0", 0, 0, 1'b0, 1'b1);
    cycle("rst1", 0, 0, 1'b0, 1'b1);
    check_eq("rst.stall", fb_stall, 1'b0);

    // Single group then fill to full.
    cycle("fill0", 4, 0, 1'b0, 1'b0);
    check_eq("fill0.pc3", if_id_packet_out[3].PC, 32'd12);
    cycle("fill1", 4, 0, 1'b0, 1'b0);
    cycle("fill2", 4, 0, 1'b0, 1'b0);
    cycle("fill3", 4, 0, 1'b0, 1'b0);
    // Full: stall high, group at PC 64 dropped unless early free is enabled.
    cycle("full_disp", 4, 4, 1'b0, 1'b0);
    cycle("after_full", 4, 0, 1'b0, 1'b0);
    while (model_q.size() > 0) cycle("drain", 0, min2(4, model_q.size()), 1'b0, 1'b0);

    // Steady-state 3-in/3-out across pointer wrap.
    for (int k = 0; k < 10; k++)
      cycle("wrap", 3, min2(3, model_q.size()), 1'b0, 1'b0);
    check_eq("wrap.count3", fb_count, 5'd3);
    while (model_q.size() > 0) cycle("drain", 0, min2(4, model_q.size()), 1'b0, 1'b0);

    // count=2, dispatch 1.
    cycle("two", 2, 0, 1'b0, 1'b0);
    cycle("one_out", 0, 1, 1'b0, 1'b0);
    cycle("drain", 0, 1, 1'b0, 1'b0);

    // Nuke mid-fill with simultaneous enqueue and dispatch.
    cycle("pre_nuke", 4, 0, 1'b0, 1'b0);
    cycle("pre_nuke", 4, 0, 1'b0, 1'b0);
    cycle("nuke", 4, 2, 1'b1, 1'b0);
    cycle("post_nuke", 4, 0, 1'b0, 1'b0);
    check_eq("post_nuke.lane0pc", if_id_packet_out[0].PC, pc_next - 32'd16);

    // Randomized traffic with occasional nuke and reset.
    for (int k = 0; k < 400; k++) begin
      nin  = $urandom_range(0, W);
      disp = $urandom_range(0, min2(model_q.size(), W));
      nk   = ($urandom_range(0, 31) == 0);
      rst  = ($urandom_range(0, 99) == 0);
      cycle("rand", nin, disp, nk, rst);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
